// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight ops plus a zero flag,
// carried through an elastic valid/ready register chain.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_ANDN = 3'b100,
    OP_ORN  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
  } beat_t;

  beat_t             head;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;
  beat_t             dat [STAGES];

  always_comb begin
    head.res = '0;
    unique case (op_e'(in_op))
      OP_NOT:  head.res = ~in_a;
      OP_AND:  head.res = in_a & in_b;
      OP_OR:   head.res = in_a | in_b;
      OP_XOR:  head.res = in_a ^ in_b;
      OP_ANDN: head.res = in_a & ~in_b;
      OP_ORN:  head.res = in_a | ~in_b;
      OP_XNOR: head.res = ~(in_a ^ in_b);
      OP_PASS: head.res = in_a;
    endcase
    head.zero = (head.res == '0);
  end

  // A stage can load if any stage at or after it is empty,
  // or the consumer takes the last beat this cycle.
  always_comb begin : ready_chain
    logic room;
    load = '0;
    room = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      room    = room | ~vld[i];
      load[i] = room;
    end
  end

  assign in_ready = load[0] & ~flush;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic  up_v;
    beat_t up_d;
    logic  vld_d, vld_q;
    beat_t dat_d, dat_q;

    if (g == 0) begin : g_src
      assign up_v = in_valid;
      assign up_d = head;
    end else begin : g_src
      assign up_v = vld[g-1];
      assign up_d = dat[g-1];
    end

    always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (load[g]) begin
        vld_d = up_v;
        if (up_v) dat_d = up_d;
      end
      if (flush) vld_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign vld[g] = vld_q;
    assign dat[g] = dat_q;
  end

  assign out_valid  = vld[STAGES-1];
  assign out_result = dat[STAGES-1].res;
  assign out_zero   = dat[STAGES-1].zero;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe,
// checked every cycle against a queue-based model.
module tb_logic_unit_pipe;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_zero;

  logic_unit_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    int           t;
  } exp_t;

  exp_t         mq [$];
  logic [W-1:0] got_r [$];
  logic         got_z [$];

  function automatic logic [W-1:0] ref_op(
    input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return a & ~b;
      3'd5: return a | ~b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  // Head beat is visible once it has spent S cycles inside.
  function automatic bit m_valid();
    return mq.size() > 0 && (cyc - mq[0].t) >= S;
  endfunction

  function automatic bit m_ready();
    return !flush && (mq.size() < S || out_ready);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      bit pop, push;
      logic [W-1:0] r;
      pop  = m_valid() && out_ready;
      push = in_valid && m_ready();
      r    = ref_op(in_op, in_a, in_b);
      if (pop) void'(mq.pop_front());
      if (flush) mq.delete();
      if (push) mq.push_back(exp_t'{r, r == '0, cyc});
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m_valid());
      if (m_valid()) begin
        chk("out_result", out_result, mq[0].res);
        chk("out_zero", out_zero, mq[0].z);
      end
      if (out_valid && out_ready) begin
        got_r.push_back(out_result);
        got_z.push_back(out_zero);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    bit acc;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_chk++;
    n_err++;
    $display("FAIL send_timeout: got in_ready 0 expected 1");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sweep [8];

  initial begin
    sweep = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h30, 8'hF3, 8'hC3, 8'hF0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    got_r.delete();
    got_z.delete();
    for (int op = 0; op < 8; op++) send(3'(op), 8'hF0, 8'hCC);
    idle(4);
    chk("sweep_count", got_r.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_r.size()) begin
        chk($sformatf("sweep_res%0d", i), got_r[i], sweep[i]);
        chk($sformatf("sweep_z%0d", i), got_z[i], 0);
      end
    end

    got_r.delete();
    got_z.delete();
    send(3'd1, 8'hAA, 8'h55);
    send(3'd0, 8'hFF, 8'h00);
    idle(4);
    chk("zero_count", got_r.size(), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < got_r.size()) begin
        chk($sformatf("zero_res%0d", i), got_r[i], 0);
        chk($sformatf("zero_z%0d", i), got_z[i], 1);
      end
    end

    got_r.delete();
    got_z.delete();
    out_ready = 1'b0;
    send(3'd3, 8'h01, 8'h00);
    send(3'd3, 8'h02, 8'h00);
    in_valid = 1'b1;
    in_op = 3'd3;
    in_a = 8'h03;
    in_b = 8'h00;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_result, 8'h01);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("popush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("popush_valid", out_valid, 1);
    chk("popush_res", out_result, 8'h02);
    @(posedge clk);
    #1;
    send(3'd3, 8'h04, 8'h00);
    idle(4);
    chk("bp_count", got_r.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_r.size()) chk($sformatf("bp_order%0d", i), got_r[i], i + 1);
    end

    out_ready = 1'b0;
    send(3'd2, 8'h11, 8'h00);
    send(3'd2, 8'h22, 8'h00);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_cleared", out_valid, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd7, 8'h5A, 8'h00);
    @(negedge clk);
    chk("post_flush_early", out_valid, 0);
    @(negedge clk);
    chk("post_flush_valid", out_valid, 1);
    chk("post_flush_res", out_result, 8'h5A);
    idle(3);

    out_ready = 1'b0;
    send(3'd7, 8'h01, 8'h00);
    send(3'd7, 8'h02, 8'h00);
    @(negedge clk);
    #2;
    chk("pre_areset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("areset_valid", out_valid, 0);
    chk("areset_res", out_result, 0);
    chk("areset_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    repeat (1500) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 3'($urandom_range(0, 7));
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    idle(6);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
